// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX register with load-use bubble, EX hold, flush, WB bypass and bubble counter
module id_ex_pipe_reg #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1_addr,
    input  logic [4:0]        id_rs2_addr,
    input  logic [4:0]        id_rd_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              id_reg_write,
    input  logic              wb_we,
    input  logic [4:0]        wb_waddr,
    input  logic [XLEN-1:0]   wb_wd,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              stall_if_id,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [4:0]        ex_rs1_addr,
    output logic [4:0]        ex_rs2_addr,
    output logic [4:0]        ex_rd_addr,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic              ex_reg_write,
    output logic [CNT_W-1:0]  bubble_cnt
);
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [4:0]        rd_addr;
        logic [CTRL_W-1:0] ctrl;
        logic              mem_read;
        logic              reg_write;
    } ex_t;

    ex_t             ex_q, ex_d, id_ex;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rs1_sel, rs2_sel;
    logic            load_use;

    // x0 reads as zero, so a nonzero match already excludes a WB write to x0
    assign rs1_sel = id_rs1_addr == 5'd0 ? '0 : (wb_we && wb_waddr == id_rs1_addr) ? wb_wd : id_rs1_data;
    assign rs2_sel = id_rs2_addr == 5'd0 ? '0 : (wb_we && wb_waddr == id_rs2_addr) ? wb_wd : id_rs2_data;

    assign load_use = ex_q.valid && ex_q.mem_read && ex_q.rd_addr != 5'd0 && id_valid &&
                      (ex_q.rd_addr == id_rs1_addr || ex_q.rd_addr == id_rs2_addr);
    assign stall_if_id = !flush && (ex_hold || load_use);

    assign id_ex = '{valid: id_valid, pc: id_pc, imm: id_imm, rs1_data: rs1_sel, rs2_data: rs2_sel,
                     rs1_addr: id_rs1_addr, rs2_addr: id_rs2_addr, rd_addr: id_rd_addr, ctrl: id_ctrl,
                     mem_read: id_valid && id_mem_read, reg_write: id_valid && id_reg_write};

    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (flush) begin
            ex_d = '0;
        end else if (ex_hold) begin
            // keep held operands coherent with writebacks that retire during the hold
            if (wb_we && wb_waddr != 5'd0 && wb_waddr == ex_q.rs1_addr) ex_d.rs1_data = wb_wd;
            if (wb_we && wb_waddr != 5'd0 && wb_waddr == ex_q.rs2_addr) ex_d.rs2_data = wb_wd;
        end else if (load_use) begin
            ex_d  = '0;
            cnt_d = cnt_q == '1 ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
            ex_d = id_ex;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_pc        = ex_q.pc;
    assign ex_imm       = ex_q.imm;
    assign ex_rs1_data  = ex_q.rs1_data;
    assign ex_rs2_data  = ex_q.rs2_data;
    assign ex_rs1_addr  = ex_q.rs1_addr;
    assign ex_rs2_addr  = ex_q.rs2_addr;
    assign ex_rd_addr   = ex_q.rd_addr;
    assign ex_ctrl      = ex_q.ctrl;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_reg_write = ex_q.reg_write;
    assign bubble_cnt   = cnt_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed checks of the ID/EX register (counter narrowed to 4 bits to reach saturation)
module tb_id_ex_pipe_reg;
    localparam int XLEN = 32, CTRL_W = 16, CNT_W = 4;

    logic clk = 0, rst = 1;
    logic id_valid = 0, id_mem_read = 0, id_reg_write = 0, wb_we = 0, ex_hold = 0, flush = 0;
    logic [XLEN-1:0] id_pc = 0, id_rs1_data = 0, id_rs2_data = 0, id_imm = 0, wb_wd = 0;
    logic [4:0] id_rs1_addr = 0, id_rs2_addr = 0, id_rd_addr = 0, wb_waddr = 0;
    logic [CTRL_W-1:0] id_ctrl = 0;
    logic stall_if_id, ex_valid, ex_mem_read, ex_reg_write;
    logic [XLEN-1:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [4:0] ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0] bubble_cnt;
    int total = 0, bad = 0;

    id_ex_pipe_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .wb_we(wb_we), .wb_waddr(wb_waddr),
        .wb_wd(wb_wd), .ex_hold(ex_hold), .flush(flush), .stall_if_id(stall_if_id),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
        .ex_rd_addr(ex_rd_addr), .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] d1,
                          input logic [4:0] r2, input logic [31:0] d2, input logic [4:0] rd,
                          input logic mr, input logic rw);
        id_valid = v; id_pc = pc; id_rs1_addr = r1; id_rs1_data = d1;
        id_rs2_addr = r2; id_rs2_data = d2; id_rd_addr = rd; id_mem_read = mr; id_reg_write = rw;
    endtask

    initial begin
        #2 rst = 0;
        #1;
        chk("rst_valid", ex_valid, 0);
        chk("rst_cnt", bubble_cnt, 0);
        chk("rst_stall", stall_if_id, 0);
        #6 rst = 1;

        // pass-through
        set_id(1, 32'h100, 5, 32'h11, 6, 32'h22, 2, 0, 1);
        id_imm = 32'hFFFF_FFF8; id_ctrl = 16'hABCD;
        step();
        chk("pt_pc", ex_pc, 32'h100);
        chk("pt_rs1", ex_rs1_data, 32'h11);
        chk("pt_imm", ex_imm, 32'hFFFF_FFF8);
        chk("pt_valid", ex_valid, 1);
        chk("pt_ctrl", ex_ctrl, 16'hABCD);
        chk("pt_rw", ex_reg_write, 1);

        // WB bypass, then x0 stays zero even with a write to x0
        set_id(1, 32'h104, 1, 32'h5, 7, 32'h0, 8, 0, 1);
        wb_we = 1; wb_waddr = 7; wb_wd = 32'hCAFE;
        step();
        chk("byp_rs2", ex_rs2_data, 32'hCAFE);
        chk("byp_rs1_nohit", ex_rs1_data, 32'h5);
        set_id(1, 32'h108, 0, 32'h1234, 0, 32'h5678, 8, 0, 1);
        wb_waddr = 0; wb_wd = 32'hBEEF;
        step();
        chk("byp_x0_rs1", ex_rs1_data, 0);
        chk("byp_x0_rs2", ex_rs2_data, 0);
        wb_we = 0;

        // load-use: lw x3 then add x4,x3,x1
        set_id(1, 32'h200, 1, 32'h40, 0, 0, 3, 1, 1);
        step();
        chk("lu_ex_load", ex_mem_read, 1);
        set_id(1, 32'h204, 3, 32'h0, 1, 32'h40, 4, 0, 1);
        #1;
        chk("lu_stall", stall_if_id, 1);
        step();
        chk("lu_bub_valid", ex_valid, 0);
        chk("lu_bub_rw", ex_reg_write, 0);
        chk("lu_bub_pc", ex_pc, 0);
        chk("lu_cnt", bubble_cnt, 1);
        chk("lu_stall_done", stall_if_id, 0);
        step();
        chk("lu_cap_pc", ex_pc, 32'h204);
        chk("lu_cap_rd", ex_rd_addr, 4);

        // hold with snoop on rs1=9
        set_id(1, 32'h10C, 9, 32'h77, 2, 32'h3, 5, 0, 1);
        step();
        chk("hd_pre_rs1", ex_rs1_data, 32'h77);
        set_id(1, 32'h300, 1, 32'h1, 2, 32'h2, 6, 0, 1);
        ex_hold = 1; wb_we = 1; wb_waddr = 9; wb_wd = 32'h55;
        #1;
        chk("hd_stall0", stall_if_id, 1);
        step();
        wb_we = 0;
        chk("hd_snoop", ex_rs1_data, 32'h55);
        chk("hd_pc0", ex_pc, 32'h10C);
        chk("hd_rs2", ex_rs2_data, 32'h3);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("hd_pc", ex_pc, 32'h10C);
            chk("hd_rs1", ex_rs1_data, 32'h55);
            chk("hd_stall", stall_if_id, 1);
        end
        ex_hold = 0;

        // flush beats hold and load-use
        set_id(1, 32'h400, 1, 32'h1, 0, 0, 3, 1, 1);
        step();
        set_id(1, 32'h404, 3, 0, 1, 32'h1, 4, 0, 1);
        ex_hold = 1; flush = 1;
        #1;
        chk("fl_stall", stall_if_id, 0);
        step();
        chk("fl_valid", ex_valid, 0);
        chk("fl_pc", ex_pc, 0);
        chk("fl_cnt", bubble_cnt, 1);
        ex_hold = 0; flush = 0;
        step();
        chk("fl_cap_pc", ex_pc, 32'h404);

        // repeated lw x3,0(x3) drives the counter to saturation
        set_id(1, 32'h500, 3, 0, 0, 0, 3, 1, 1);
        step();
        for (int i = 0; i < 14; i++) begin
            step();
            step();
        end
        chk("sat_cnt15", bubble_cnt, 4'hF);
        step();
        chk("sat_bub", ex_valid, 0);
        chk("sat_hold", bubble_cnt, 4'hF);

        // async reset mid-hold
        step();
        ex_hold = 1;
        #2 rst = 0;
        #1;
        chk("mr_valid", ex_valid, 0);
        chk("mr_pc", ex_pc, 0);
        chk("mr_cnt", bubble_cnt, 0);
        chk("mr_stall", stall_if_id, 1);
        ex_hold = 0;
        #1;
        chk("mr_stall_clr", stall_if_id, 0);
        rst = 1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
